// File: rtl/sar_search_ctrl.sv
// -----------------------------------------------------------------------------
// sar_search_ctrl
//
// Successive-approximation search controller. It drives a trial value on
// `probe` into the B input of an external magnitude comparator and resolves
// one bit per step from the comparator's gt/eq/lt flags. The result is the
// unknown A operand.
//
// Parameters
//   WIDTH          operand width; also the number of search steps
//   SETTLE_CYCLES  cycles each probe is held before the flags are sampled
//                  (legal range 1..15)
//
// Ports
//   clk     in   system clock, rising-edge active
//   rst_n   in   asynchronous active-low reset
//   start   in   search request, honoured only while idle
//   a_gt_b  in   comparator flag, A > probe
//   a_eq_b  in   comparator flag, A == probe
//   a_lt_b  in   comparator flag, A < probe
//   probe   out  trial value for the comparator B input
//   result  out  final search value, held until overwritten by the next search
//   busy    out  high while the search is running
//   done    out  one-cycle pulse when result/exact/err are valid
//   exact   out  an equal flag was seen during the last search
//   err     out  a flag sample that was not one-hot was seen during the last search
//
// Build option
//   SAR_EARLY_EXIT_EN  when defined, an equal flag ends the search at once.
//                      When undefined, equal is treated like greater-than and
//                      every search runs all WIDTH steps. The final result and
//                      exact flag are the same either way.
// -----------------------------------------------------------------------------
module sar_search_ctrl #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_gt_b,
  input  logic             a_eq_b,
  input  logic             a_lt_b,
  output logic [WIDTH-1:0] probe,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             exact,
  output logic             err
);

  localparam int               IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0]       CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDXW-1:0]  IDX_MSB  = IDXW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONLY = ONE << (WIDTH - 1);

`ifdef SAR_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_probe, w_probe_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [IDXW-1:0]  r_idx, w_idx_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_exact, w_exact_nxt;
  logic             r_err, w_err_nxt;

  logic             w_sample;
  logic             w_onehot;
  logic             w_last_step;
  logic [WIDTH-1:0] w_bit_mask;
  logic [WIDTH-1:0] w_resolved;

  // The flags are only trusted on the last cycle of each settle window.
  assign w_sample    = (r_cnt == CNT_LAST);
  assign w_last_step = (r_idx == '0);
  assign w_bit_mask  = ONE << r_idx;

  // A three-way XOR is 1 for one or three set flags; exclude the all-set case.
  assign w_onehot = (a_gt_b ^ a_eq_b ^ a_lt_b) & ~(a_gt_b & a_eq_b & a_lt_b);

  // The bit under test is already set in the probe; only "less than" clears it.
  // Equal keeps it, which is what makes the full-length search converge on A.
  assign w_resolved = a_lt_b ? (r_probe & ~w_bit_mask) : r_probe;

  // Next-state and datapath decisions. Every register keeps its value unless
  // the current state says otherwise.
  always_comb begin
    w_state_nxt  = r_state;
    w_probe_nxt  = r_probe;
    w_result_nxt = r_result;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_exact_nxt  = r_exact;
    w_err_nxt    = r_err;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_probe_nxt = MSB_ONLY;
          w_idx_nxt   = IDX_MSB;
          w_cnt_nxt   = '0;
          w_exact_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          w_state_nxt = SETTLE;
        end
      end

      SETTLE: begin
        if (!w_sample) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else if (!w_onehot) begin
          // A broken flag encoding aborts the search with the probe as it stands.
          w_err_nxt    = 1'b1;
          w_result_nxt = r_probe;
          w_state_nxt  = DONE;
        end else begin
          if (a_eq_b) begin
            w_exact_nxt = 1'b1;
          end
          if (a_eq_b && EARLY_EXIT) begin
            w_result_nxt = r_probe;
            w_state_nxt  = DONE;
          end else if (w_last_step) begin
            w_result_nxt = w_resolved;
            w_state_nxt  = DONE;
          end else begin
            // Commit the current bit and raise the next lower one as the new trial.
            w_probe_nxt = w_resolved | (w_bit_mask >> 1);
            w_idx_nxt   = r_idx - IDXW'(1);
            w_cnt_nxt   = '0;
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any search without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_probe  <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_exact  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_probe  <= w_probe_nxt;
      r_result <= w_result_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_exact  <= w_exact_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign probe  = r_probe;
  assign result = r_result;
  assign exact  = r_exact;
  assign err    = r_err;
  assign busy   = (r_state == SETTLE);
  assign done   = (r_state == DONE);

endmodule
